// File: rtl/amm_slave_regfile.sv
// amm_slave_regfile: Avalon-MM slave register file exposing board I/O.
//   Register map (word address): 0 DISPLAY, 1 LEDR, 2 SWITCH (RO), 3 IRQ_STATUS (W1C),
//   4 IRQ_ENABLE, 5 COUNT, 6 ID (RO), 7 SCRATCH.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   avs_address/read/write       Avalon-MM request; accepted when avs_waitrequest is low
//   avs_writedata/byteenable     write payload and byte lanes
//   avs_waitrequest              combinational stall (held high during reset)
//   avs_readdata/readdatavalid   registered read response, one cycle after accept
//   sw_in                        raw asynchronous switches
//   display_data, led_out        conduit outputs to HEX digits and LEDR
//   irq                          registered level interrupt
module amm_slave_regfile #(
    parameter int unsigned ADDRESSWIDTH = 3,
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] ID_VALUE     = 32'hA5A5_0001
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDRESSWIDTH-1:0] avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATAWIDTH-1:0]    avs_writedata,
    input  logic [3:0]              avs_byteenable,
    output logic                    avs_waitrequest,
    output logic [DATAWIDTH-1:0]    avs_readdata,
    output logic                    avs_readdatavalid,
    input  logic [17:0]             sw_in,
    output logic [DATAWIDTH-1:0]    display_data,
    output logic [17:0]             led_out,
    output logic                    irq
);

    localparam int unsigned SW_W  = 18;
    localparam int unsigned CNT_W = 16;

    localparam logic [ADDRESSWIDTH-1:0] A_DISPLAY  = ADDRESSWIDTH'(0);
    localparam logic [ADDRESSWIDTH-1:0] A_LEDR     = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] A_SWITCH   = ADDRESSWIDTH'(2);
    localparam logic [ADDRESSWIDTH-1:0] A_IRQ_STAT = ADDRESSWIDTH'(3);
    localparam logic [ADDRESSWIDTH-1:0] A_IRQ_EN   = ADDRESSWIDTH'(4);
    localparam logic [ADDRESSWIDTH-1:0] A_COUNT    = ADDRESSWIDTH'(5);
    localparam logic [ADDRESSWIDTH-1:0] A_ID       = ADDRESSWIDTH'(6);
    localparam logic [ADDRESSWIDTH-1:0] A_SCRATCH  = ADDRESSWIDTH'(7);

    logic [3:0]           wcnt, wcnt_nxt;
    logic                 req_c, accept_c, wr_acc_c, rd_acc_c;
    logic [SW_W-1:0]      sw_meta, sw_sync, sw_prev;
    logic                 sw_edge_c, irq_clr_c;
    logic                 irq_status, irq_status_nxt;
    logic                 irq_enable, irq_enable_nxt;
    logic [CNT_W-1:0]     wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt;
    logic [DATAWIDTH-1:0] scratch, scratch_nxt;
    logic [DATAWIDTH-1:0] display_nxt, rd_mux_c;
    logic [17:0]          led_nxt;

    // Byte-lane merge of write data into an existing word.
    function automatic logic [DATAWIDTH-1:0] merge_be(input logic [DATAWIDTH-1:0] old,
                                                      input logic [DATAWIDTH-1:0] wd,
                                                      input logic [3:0]           be);
        logic [DATAWIDTH-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Handshake: stall until wcnt reaches WAIT_STATES; write wins over a simultaneous read.
    assign req_c           = avs_read | avs_write;
    assign avs_waitrequest = !reset_n || (req_c && (wcnt != 4'(WAIT_STATES)));
    assign accept_c        = req_c && !avs_waitrequest;
    assign wr_acc_c        = accept_c && avs_write;
    assign rd_acc_c        = accept_c && avs_read && !avs_write;

    assign sw_edge_c = (sw_sync != sw_prev);
    assign irq_clr_c = wr_acc_c && (avs_address == A_IRQ_STAT)
                       && avs_byteenable[0] && avs_writedata[0];

    // Read mux on pre-update register values.
    always_comb begin
        rd_mux_c = '0;
        case (avs_address)
            A_DISPLAY:  rd_mux_c = display_data;
            A_LEDR:     rd_mux_c = DATAWIDTH'(led_out);
            A_SWITCH:   rd_mux_c = DATAWIDTH'(sw_sync);
            A_IRQ_STAT: rd_mux_c = DATAWIDTH'(irq_status);
            A_IRQ_EN:   rd_mux_c = DATAWIDTH'(irq_enable);
            A_COUNT:    rd_mux_c = {rd_cnt, wr_cnt};
            A_ID:       rd_mux_c = DATAWIDTH'(ID_VALUE);
            A_SCRATCH:  rd_mux_c = scratch;
            default:    rd_mux_c = '0;
        endcase
    end

    // Next-state for registers, counters and wait-state counter.
    always_comb begin
        wcnt_nxt       = wcnt;
        display_nxt    = display_data;
        led_nxt        = led_out;
        irq_enable_nxt = irq_enable;
        scratch_nxt    = scratch;
        wr_cnt_nxt     = wr_cnt;
        rd_cnt_nxt     = rd_cnt;

        if (!req_c || accept_c) wcnt_nxt = 4'd0;
        else                    wcnt_nxt = wcnt + 4'd1;

        if (wr_acc_c) begin
            case (avs_address)
                A_DISPLAY: display_nxt = merge_be(display_data, avs_writedata, avs_byteenable);
                A_LEDR: begin
                    if (avs_byteenable[0]) led_nxt[7:0]   = avs_writedata[7:0];
                    if (avs_byteenable[1]) led_nxt[15:8]  = avs_writedata[15:8];
                    if (avs_byteenable[2]) led_nxt[17:16] = avs_writedata[17:16];
                end
                A_IRQ_EN:  if (avs_byteenable[0]) irq_enable_nxt = avs_writedata[0];
                A_SCRATCH: scratch_nxt = merge_be(scratch, avs_writedata, avs_byteenable);
                default: ;
            endcase
        end

        // A write to COUNT clears both fields and overrides its own increment.
        if (wr_acc_c && (avs_address == A_COUNT)) begin
            wr_cnt_nxt = '0;
            rd_cnt_nxt = '0;
        end else begin
            if (wr_acc_c) wr_cnt_nxt = wr_cnt + 16'd1;
            if (rd_acc_c) rd_cnt_nxt = rd_cnt + 16'd1;
        end

        // New edge has priority over a simultaneous W1C clear.
        irq_status_nxt = sw_edge_c | (irq_status & ~irq_clr_c);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt              <= '0;
            sw_meta           <= '0;
            sw_sync           <= '0;
            sw_prev           <= '0;
            display_data      <= '0;
            led_out           <= '0;
            irq_status        <= 1'b0;
            irq_enable        <= 1'b0;
            wr_cnt            <= '0;
            rd_cnt            <= '0;
            scratch           <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            wcnt              <= wcnt_nxt;
            sw_meta           <= sw_in;
            sw_sync           <= sw_meta;
            sw_prev           <= sw_sync;
            display_data      <= display_nxt;
            led_out           <= led_nxt;
            irq_status        <= irq_status_nxt;
            irq_enable        <= irq_enable_nxt;
            wr_cnt            <= wr_cnt_nxt;
            rd_cnt            <= rd_cnt_nxt;
            scratch           <= scratch_nxt;
            avs_readdata      <= rd_acc_c ? rd_mux_c : '0;
            avs_readdatavalid <= rd_acc_c;
            irq               <= irq_status & irq_enable;
        end
    end

endmodule

// File: tb/tb_amm_slave_regfile.sv
// tb_amm_slave_regfile: directed bench for amm_slave_regfile.
//   Instance 0 uses WAIT_STATES=1, instance 1 uses WAIT_STATES=0; both share clock,
//   reset and switches.
module tb_amm_slave_regfile;

    logic        clk;
    logic        reset_n;
    logic [17:0] sw_in;

    logic [2:0]  address [2];
    logic        rd      [2];
    logic        wr      [2];
    logic [31:0] wdata   [2];
    logic [3:0]  be      [2];
    logic        waitreq [2];
    logic [31:0] rdata   [2];
    logic        rdv     [2];
    logic [31:0] disp    [2];
    logic [17:0] led     [2];
    logic        irq     [2];

    int n_cmp = 0;
    int n_bad = 0;

    amm_slave_regfile #(.WAIT_STATES(1)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .avs_address(address[0]), .avs_read(rd[0]), .avs_write(wr[0]),
        .avs_writedata(wdata[0]), .avs_byteenable(be[0]),
        .avs_waitrequest(waitreq[0]), .avs_readdata(rdata[0]),
        .avs_readdatavalid(rdv[0]), .sw_in(sw_in),
        .display_data(disp[0]), .led_out(led[0]), .irq(irq[0])
    );

    amm_slave_regfile #(.WAIT_STATES(0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .avs_address(address[1]), .avs_read(rd[1]), .avs_write(wr[1]),
        .avs_writedata(wdata[1]), .avs_byteenable(be[1]),
        .avs_waitrequest(waitreq[1]), .avs_readdata(rdata[1]),
        .avs_readdatavalid(rdv[1]), .sw_in(sw_in),
        .display_data(disp[1]), .led_out(led[1]), .irq(irq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one write, wait out stalls (bounded), check the stall count.
    task automatic bus_write(input int d, input logic [2:0] a, input logic [31:0] dat,
                             input logic [3:0] b, input int exp_stalls, input string tag);
        int stalls;
        stalls   = 0;
        address[d] = a;
        wdata[d] = dat;
        be[d]    = b;
        wr[d]    = 1'b1;
        #1;
        while (waitreq[d] && stalls < 32) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        wr[d] = 1'b0;
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    endtask

    // Issue one read, check stalls, response data one cycle after accept, then strobe drop.
    task automatic bus_read(input int d, input logic [2:0] a, input logic [31:0] exp_data,
                            input int exp_stalls, input string tag);
        int stalls;
        stalls     = 0;
        address[d] = a;
        rd[d]      = 1'b1;
        #1;
        while (waitreq[d] && stalls < 32) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_rdv"}, 32'(rdv[d]), 32'd1);
        check({tag, "_data"}, rdata[d], exp_data);
        cyc();
        check({tag, "_rdv_drop"}, 32'(rdv[d]), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        sw_in   = '0;
        for (int i = 0; i < 2; i++) begin
            address[i] = '0;
            rd[i]      = 1'b0;
            wr[i]      = 1'b0;
            wdata[i]   = '0;
            be[i]      = '0;
        end

        // Reset state.
        #3;
        check("rst_wait0", 32'(waitreq[0]), 32'd1);
        check("rst_wait1", 32'(waitreq[1]), 32'd1);
        check("rst_rdv", 32'(rdv[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_irq", 32'(irq[0]), 32'd0);
        check("rst_disp", disp[0], 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();

        // ID read with one wait state.
        bus_read(0, 3'd6, 32'hA5A5_0001, 1, "id_read");

        // Byte-enabled display write.
        bus_write(0, 3'd0, 32'h1234_5678, 4'b0101, 1, "disp_wr");
        check("disp_out", disp[0], 32'h0034_0078);
        bus_read(0, 3'd0, 32'h0034_0078, 1, "disp_rd");

        // LEDR, RO SWITCH, scratch.
        bus_write(0, 3'd1, 32'h0003_FFFF, 4'hF, 1, "led_wr");
        check("led_out", 32'(led[0]), 32'h0003_FFFF);
        bus_read(0, 3'd1, 32'h0003_FFFF, 1, "led_rd");
        bus_write(0, 3'd2, 32'hFFFF_FFFF, 4'hF, 1, "sw_wr");
        bus_read(0, 3'd2, 32'h0000_0000, 1, "sw_rd");
        bus_write(0, 3'd7, 32'h5555_AAAA, 4'hF, 1, "scr_wr");
        bus_read(0, 3'd7, 32'h5555_AAAA, 1, "scr_rd");

        // Switch edge -> status -> irq, then W1C clear.
        bus_write(0, 3'd4, 32'h0000_0001, 4'h1, 1, "ien_wr");
        sw_in[3] = 1'b1;
        cyc();
        cyc();
        cyc();
        check("irq_lag", 32'(irq[0]), 32'd0);
        cyc();
        check("irq_set", 32'(irq[0]), 32'd1);
        bus_read(0, 3'd3, 32'h0000_0001, 1, "stat_rd");
        bus_read(0, 3'd2, 32'h0000_0008, 1, "sw_rd8");
        bus_write(0, 3'd3, 32'h0000_0001, 4'h1, 1, "w1c");
        check("irq_hold", 32'(irq[0]), 32'd1);
        cyc();
        check("irq_clr", 32'(irq[0]), 32'd0);
        bus_read(0, 3'd3, 32'h0000_0000, 1, "stat_rd0");

        // Write counter wrap on the zero-wait instance: 65537 back-to-back writes.
        address[1] = 3'd7;
        wdata[1]   = 32'hCAFE_F00D;
        be[1]      = 4'hF;
        wr[1]      = 1'b1;
        #1;
        check("ws0_nowait", 32'(waitreq[1]), 32'd0);
        repeat (65537) @(posedge clk);
        #1;
        wr[1] = 1'b0;
        bus_read(1, 3'd5, 32'h0000_0001, 0, "cnt_wrap");
        bus_write(1, 3'd5, 32'h0000_0000, 4'h0, 0, "cnt_clr");
        bus_read(1, 3'd5, 32'h0000_0000, 0, "cnt_zero");
        bus_read(1, 3'd5, 32'h0001_0000, 0, "cnt_rd1");

        // Back-to-back reads with no wait states.
        bus_write(1, 3'd0, 32'hDEAD_BEEF, 4'hF, 0, "disp1_wr");
        rd[1]      = 1'b1;
        address[1] = 3'd0;
        #1;
        check("b2b_nowait", 32'(waitreq[1]), 32'd0);
        cyc();
        address[1] = 3'd6;
        check("b2b_rdv0", 32'(rdv[1]), 32'd1);
        check("b2b_d0", rdata[1], 32'hDEAD_BEEF);
        cyc();
        address[1] = 3'd7;
        check("b2b_rdv1", 32'(rdv[1]), 32'd1);
        check("b2b_d1", rdata[1], 32'hA5A5_0001);
        cyc();
        rd[1] = 1'b0;
        check("b2b_rdv2", 32'(rdv[1]), 32'd1);
        check("b2b_d2", rdata[1], 32'hCAFE_F00D);
        cyc();
        check("b2b_end", 32'(rdv[1]), 32'd0);

        // Reset asserted in the middle of a stalled read.
        rd[0]      = 1'b1;
        address[0] = 3'd0;
        #1;
        check("mid_stall", 32'(waitreq[0]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wait", 32'(waitreq[0]), 32'd1);
        @(posedge clk);
        #1;
        rd[0]   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_rdv", 32'(rdv[0]), 32'd0);
            cyc();
        end
        check("post_rst_disp", disp[0], 32'd0);
        check("post_rst_led", 32'(led[0]), 32'd0);
        check("post_rst_irq", 32'(irq[0]), 32'd0);
        bus_read(0, 3'd7, 32'h0000_0000, 1, "post_rst_scr");
        bus_read(0, 3'd4, 32'h0000_0000, 1, "post_rst_ien");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
